// File: rtl/exu_gpr_datapath_pkg.sv
// Shared widths, ALU op-codes and operand-select codes for the RV32 execute slice.
package exu_gpr_datapath_pkg;

    localparam int unsigned CPU_WIDTH      = 32;
    localparam int unsigned EXU_OPT_WIDTH  = 4;
    localparam int unsigned EXU_SEL_WIDTH  = 3;
    localparam int unsigned GPR_ADDR_WIDTH = 5;
    localparam int unsigned GPR_DEPTH      = 32;

    localparam logic [EXU_OPT_WIDTH-1:0] EXU_ADD  = 4'd0;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SUB  = 4'd1;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_AND  = 4'd2;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_OR   = 4'd3;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_XOR  = 4'd4;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLL  = 4'd5;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRL  = 4'd6;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRA  = 4'd7;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLT  = 4'd8;
    localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLTU = 4'd9;

    localparam logic [EXU_SEL_WIDTH-1:0] SEL_RS1_RS2 = 3'd0;
    localparam logic [EXU_SEL_WIDTH-1:0] SEL_RS1_IMM = 3'd1;
    localparam logic [EXU_SEL_WIDTH-1:0] SEL_PC_IMM  = 3'd2;
    localparam logic [EXU_SEL_WIDTH-1:0] SEL_0_IMM   = 3'd3;
    localparam logic [EXU_SEL_WIDTH-1:0] SEL_PC_4    = 3'd4;

endpackage

// File: rtl/gpr_file.sv
// 32-entry general-purpose register file: x0 hard-wired to zero, two
// combinational read ports, one synchronous write port, async clear.
module gpr_file
    import exu_gpr_datapath_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rstn_i,
    input  logic                      wr_en_i,
    input  logic [GPR_ADDR_WIDTH-1:0] addr_rd_i,
    input  logic [DATA_WIDTH-1:0]     data_rd_i,
    input  logic [GPR_ADDR_WIDTH-1:0] addr_rs1_i,
    input  logic [GPR_ADDR_WIDTH-1:0] addr_rs2_i,
    output logic [DATA_WIDTH-1:0]     data_rs1_o,
    output logic [DATA_WIDTH-1:0]     data_rs2_o
);

    logic [DATA_WIDTH-1:0] regs_q [1:GPR_DEPTH-1];

    // x0 has no storage, so a write to address 0 never matches any entry.
    for (genvar i = 1; i < int'(GPR_DEPTH); i++) begin : g_reg
        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                regs_q[i] <= '0;
            end else if (wr_en_i && (addr_rd_i == GPR_ADDR_WIDTH'(i))) begin
                regs_q[i] <= data_rd_i;
            end
        end
    end

    always_comb begin
        data_rs1_o = '0;
        data_rs2_o = '0;
        for (int i = 1; i < int'(GPR_DEPTH); i++) begin
            if (addr_rs1_i == GPR_ADDR_WIDTH'(i)) data_rs1_o = regs_q[i];
            if (addr_rs2_i == GPR_ADDR_WIDTH'(i)) data_rs2_o = regs_q[i];
        end
    end

endmodule

// File: rtl/exu_gpr_datapath.sv
// Execute-side datapath slice: reset conditioner flop, GPR file and the
// combinational ALU with operand selection and zero flag.
module exu_gpr_datapath #(
    parameter int unsigned CPU_WIDTH     = exu_gpr_datapath_pkg::CPU_WIDTH,
    parameter int unsigned EXU_OPT_WIDTH = exu_gpr_datapath_pkg::EXU_OPT_WIDTH,
    parameter int unsigned EXU_SEL_WIDTH = exu_gpr_datapath_pkg::EXU_SEL_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic                     rstn_sync,
    input  logic                     wr_en_Rd,
    input  logic [4:0]               addr_Rd,
    input  logic [CPU_WIDTH-1:0]     data_Rd,
    input  logic [4:0]               addr_Rs1,
    input  logic [4:0]               addr_Rs2,
    output logic [CPU_WIDTH-1:0]     data_Rs1,
    output logic [CPU_WIDTH-1:0]     data_Rs2,
    input  logic [CPU_WIDTH-1:0]     pc,
    input  logic [CPU_WIDTH-1:0]     imm,
    input  logic [EXU_OPT_WIDTH-1:0] exu_opt_code,
    input  logic [EXU_SEL_WIDTH-1:0] exu_sel_code,
    output logic [CPU_WIDTH-1:0]     exu_res,
    output logic                     zero
);
    import exu_gpr_datapath_pkg::*;

    localparam int unsigned SHAMT_WIDTH = $clog2(CPU_WIDTH);

    logic                   rstn_sync_q;
    logic [CPU_WIDTH-1:0]   op_a;
    logic [CPU_WIDTH-1:0]   op_b;
    logic [SHAMT_WIDTH-1:0] shamt;

    // Reset conditioner: asserts asynchronously, releases on the next edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstn_sync_q <= 1'b0;
        end else begin
            rstn_sync_q <= 1'b1;
        end
    end

    assign rstn_sync = rstn_sync_q;

    gpr_file #(
        .DATA_WIDTH (CPU_WIDTH)
    ) u_gpr_file (
        .clk        (clk),
        .rstn_i     (rstn_sync_q),
        .wr_en_i    (wr_en_Rd),
        .addr_rd_i  (addr_Rd),
        .data_rd_i  (data_Rd),
        .addr_rs1_i (addr_Rs1),
        .addr_rs2_i (addr_Rs2),
        .data_rs1_o (data_Rs1),
        .data_rs2_o (data_Rs2)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (exu_sel_code)
            SEL_RS1_RS2: begin op_a = data_Rs1; op_b = data_Rs2;          end
            SEL_RS1_IMM: begin op_a = data_Rs1; op_b = imm;               end
            SEL_PC_IMM:  begin op_a = pc;       op_b = imm;               end
            SEL_0_IMM:   begin op_a = '0;       op_b = imm;               end
            SEL_PC_4:    begin op_a = pc;       op_b = CPU_WIDTH'(4);     end
            default:     begin op_a = '0;       op_b = '0;                end
        endcase
    end

    assign shamt = op_b[SHAMT_WIDTH-1:0];

    always_comb begin
        exu_res = '0;
        case (exu_opt_code)
            EXU_ADD:  exu_res = op_a + op_b;
            EXU_SUB:  exu_res = op_a - op_b;
            EXU_AND:  exu_res = op_a & op_b;
            EXU_OR:   exu_res = op_a | op_b;
            EXU_XOR:  exu_res = op_a ^ op_b;
            EXU_SLL:  exu_res = op_a << shamt;
            EXU_SRL:  exu_res = op_a >> shamt;
            EXU_SRA:  exu_res = CPU_WIDTH'($signed(op_a) >>> shamt);
            EXU_SLT:  exu_res = CPU_WIDTH'($signed(op_a) < $signed(op_b));
            EXU_SLTU: exu_res = CPU_WIDTH'(op_a < op_b);
            default:  exu_res = '0;
        endcase
    end

    assign zero = (exu_res == '0);

endmodule

// File: tb/tb_exu_gpr_datapath.sv
// Directed bench for exu_gpr_datapath: expected values queued as stimulus is
// applied, then drained and compared once the combinational outputs settle.
module tb_exu_gpr_datapath;

    typedef enum int { S_RS1, S_RS2, S_RES, S_ZERO, S_RSTN } sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        rstn_sync;
    logic        wr_en_Rd;
    logic [4:0]  addr_Rd;
    logic [31:0] data_Rd;
    logic [4:0]  addr_Rs1;
    logic [4:0]  addr_Rs2;
    logic [31:0] data_Rs1;
    logic [31:0] data_Rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  exu_opt_code;
    logic [2:0]  exu_sel_code;
    logic [31:0] exu_res;
    logic        zero;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    exu_gpr_datapath dut (
        .clk          (clk),
        .rstn         (rstn),
        .rstn_sync    (rstn_sync),
        .wr_en_Rd     (wr_en_Rd),
        .addr_Rd      (addr_Rd),
        .data_Rd      (data_Rd),
        .addr_Rs1     (addr_Rs1),
        .addr_Rs2     (addr_Rs2),
        .data_Rs1     (data_Rs1),
        .data_Rs2     (data_Rs2),
        .pc           (pc),
        .imm          (imm),
        .exu_opt_code (exu_opt_code),
        .exu_sel_code (exu_sel_code),
        .exu_res      (exu_res),
        .zero         (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input sig_e s, input logic [31:0] e);
        exp_t t;
        t.tag = tag;
        t.sig = s;
        t.exp = e;
        sb.push_back(t);
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drain();
        exp_t        t;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            t = sb.pop_front();
            case (t.sig)
                S_RS1:   obs = data_Rs1;
                S_RS2:   obs = data_Rs2;
                S_RES:   obs = exu_res;
                S_ZERO:  obs = {31'd0, zero};
                default: obs = {31'd0, rstn_sync};
            endcase
            tests_run++;
            assert (obs === t.exp) else begin
                tests_failed++;
                $error("FAIL %s observed=%h expected=%h", t.tag, obs, t.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        addr_Rd  = a;
        data_Rd  = d;
        wr_en_Rd = 1'b1;
        tick();
        wr_en_Rd = 1'b0;
    endtask

    task automatic alu(input logic [2:0] sel, input logic [3:0] op);
        exu_sel_code = sel;
        exu_opt_code = op;
    endtask

    initial begin
        rstn         = 1'b0;
        wr_en_Rd     = 1'b0;
        addr_Rd      = '0;
        data_Rd      = '0;
        addr_Rs1     = 5'd7;
        addr_Rs2     = 5'd5;
        pc           = '0;
        imm          = '0;
        exu_opt_code = 4'd0;
        exu_sel_code = 3'd0;

        // Reset held for three edges with a write pending to x7.
        wr_en_Rd = 1'b1;
        addr_Rd  = 5'd7;
        data_Rd  = 32'hAAAA_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            push("rst_rstn_sync", S_RSTN, 32'd0);
            push("rst_rs1",       S_RS1,  32'd0);
            push("rst_rs2",       S_RS2,  32'd0);
            drain();
        end
        rstn = 1'b1;
        push("release_pre_edge", S_RSTN, 32'd0);
        drain();
        tick();
        wr_en_Rd = 1'b0;
        push("release_post_edge", S_RSTN, 32'd1);
        push("write_in_reset_ignored", S_RS1, 32'd0);
        drain();

        // Basic write/read and x0.
        write_reg(5'd5, 32'hDEAD_BEEF);
        addr_Rs1 = 5'd5;
        push("x5_read", S_RS1, 32'hDEAD_BEEF);
        drain();
        write_reg(5'd0, 32'h0000_1234);
        addr_Rs1 = 5'd0;
        addr_Rs2 = 5'd0;
        push("x0_rs1", S_RS1, 32'd0);
        push("x0_rs2", S_RS2, 32'd0);
        drain();

        // No bypass: same-cycle read returns the old value.
        addr_Rs1 = 5'd5;
        addr_Rs2 = 5'd5;
        addr_Rd  = 5'd5;
        data_Rd  = 32'h0000_0001;
        wr_en_Rd = 1'b1;
        push("no_bypass", S_RS1, 32'hDEAD_BEEF);
        push("same_addr_rs2", S_RS2, 32'hDEAD_BEEF);
        drain();
        tick();
        wr_en_Rd = 1'b0;
        push("after_write", S_RS1, 32'h0000_0001);
        drain();

        // Arithmetic wrap and zero flag.
        write_reg(5'd1, 32'h7FFF_FFFF);
        write_reg(5'd2, 32'h0000_0001);
        addr_Rs1 = 5'd1;
        addr_Rs2 = 5'd2;
        alu(3'd0, 4'd0);
        push("add_ovf", S_RES, 32'h8000_0000);
        push("add_zero", S_ZERO, 32'd0);
        drain();
        alu(3'd0, 4'd1);
        push("sub", S_RES, 32'h7FFF_FFFE);
        drain();
        alu(3'd0, 4'd2);
        push("and", S_RES, 32'h0000_0001);
        drain();
        alu(3'd0, 4'd4);
        push("xor", S_RES, 32'h7FFF_FFFE);
        drain();
        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        alu(3'd0, 4'd1);
        push("sub_eq", S_RES, 32'd0);
        push("sub_eq_zero", S_ZERO, 32'd1);
        drain();

        // Signed vs unsigned compare.
        write_reg(5'd1, 32'hFFFF_FFFF);
        write_reg(5'd2, 32'h0000_0001);
        alu(3'd0, 4'd8);
        push("slt", S_RES, 32'd1);
        push("slt_zero", S_ZERO, 32'd0);
        drain();
        alu(3'd0, 4'd9);
        push("sltu", S_RES, 32'd0);
        push("sltu_zero", S_ZERO, 32'd1);
        drain();
        alu(3'd0, 4'd3);
        push("or", S_RES, 32'hFFFF_FFFF);
        drain();

        // Shifts use only imm[4:0].
        write_reg(5'd1, 32'h8000_0000);
        imm = 32'h0000_0021;
        alu(3'd1, 4'd7);
        push("sra", S_RES, 32'hC000_0000);
        drain();
        alu(3'd1, 4'd6);
        push("srl", S_RES, 32'h4000_0000);
        drain();
        alu(3'd1, 4'd5);
        push("sll", S_RES, 32'd0);
        push("sll_zero", S_ZERO, 32'd1);
        drain();

        // Operand selection.
        pc  = 32'h8000_0000;
        imm = 32'h0000_1000;
        alu(3'd2, 4'd0);
        push("sel_pc_imm", S_RES, 32'h8000_1000);
        drain();
        alu(3'd3, 4'd0);
        push("sel_0_imm", S_RES, 32'h0000_1000);
        drain();
        alu(3'd4, 4'd0);
        push("sel_pc_4", S_RES, 32'h8000_0004);
        drain();
        alu(3'd5, 4'd0);
        push("sel_unused", S_RES, 32'd0);
        drain();
        alu(3'd2, 4'd12);
        push("op_unused", S_RES, 32'd0);
        push("op_unused_zero", S_ZERO, 32'd1);
        drain();

        // Async reset between edges: no clock edge needed to clear.
        addr_Rs1 = 5'd5;
        addr_Rs2 = 5'd1;
        alu(3'd4, 4'd0);
        push("pre_rst_x5", S_RS1, 32'h0000_0001);
        drain();
        rstn = 1'b0;
        push("async_rstn_sync", S_RSTN, 32'd0);
        push("async_rs1", S_RS1, 32'd0);
        push("async_rs2", S_RS2, 32'd0);
        push("async_res_pc4", S_RES, 32'h8000_0004);
        drain();
        rstn = 1'b1;
        tick();
        push("rerelease", S_RSTN, 32'd1);
        push("rerelease_rs1", S_RS1, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
